// File: rtl/maxnet_n.sv
// maxnet_n: iterative winner-take-all network over N fixed-point channels.
// A run alternates two passes. ACC walks the channels to gather the total
// activity, the count of non-zero channels and the largest channel. UPDATE
// walks them again, and each channel is inhibited by the sum of all the
// other channels. The run stops when at most one channel remains non-zero,
// or when the iteration limit is reached.
module maxnet_n #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int MAX_ITER = 255,
  localparam int IW      = $clog2(N),
  localparam int CW      = $clog2(MAX_ITER + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   eps,
  input  logic [N*W-1:0] in_flat,
  output logic           busy,
  output logic           finish,
  output logic [W-1:0]   out,
  output logic [IW-1:0]  winner_idx,
  output logic           no_winner,
  output logic           timeout,
  output logic [CW-1:0]  iter_count
);

  localparam int SW = W + IW;     // running-sum width, wide enough to never overflow
  localparam int PW = 2 * W + IW; // full inhibition product width
  localparam int XW = PW + 1;     // headroom for the activation plus the inhibition
  localparam int NW = IW + 1;     // non-zero counter must be able to reach N

  localparam logic [IW-1:0]       IDX_LAST  = IW'(N - 1);
  localparam logic [IW-1:0]       IDX_ONE   = IW'(1);
  localparam logic [CW-1:0]       ITER_LAST = CW'(MAX_ITER);
  localparam logic [CW-1:0]       ITER_ONE  = CW'(1);
  localparam logic [NW-1:0]       NZ_ONE    = NW'(1);
  localparam logic signed [W-1:0] AMAX_W    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] AMAX_X   = {{(XW-W){1'b0}}, AMAX_W};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_r, state_nxt_s;

  logic signed [W-1:0]  a_r [N];
  logic signed [W-1:0]  eps_r;
  logic signed [SW-1:0] sum_r;
  logic [NW-1:0]        nz_r;
  logic signed [W-1:0]  max_r;
  logic [IW-1:0]        arg_r;
  logic [IW-1:0]        idx_r;
  logic [CW-1:0]        iter_r;

  logic [W-1:0]         out_r;
  logic [IW-1:0]        winner_r;
  logic                 no_winner_r;
  logic                 timeout_r;
  logic [CW-1:0]        iter_count_r;

  logic signed [W-1:0]  cur_a_s;
  logic signed [SW-1:0] cur_ext_s;
  logic                 last_s;
  logic signed [SW-1:0] acc_sum_s;
  logic [NW-1:0]        acc_nz_s;
  logic signed [W-1:0]  acc_max_s;
  logic [IW-1:0]        acc_arg_s;
  logic                 acc_few_s;
  logic                 acc_tmo_s;
  logic signed [SW-1:0] diff_s;
  logic signed [PW-1:0] eps_ext_s;
  logic signed [PW-1:0] diff_ext_s;
  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] shift_s;
  logic signed [XW-1:0] sum_new_s;
  logic signed [W-1:0]  upd_a_s;

  assign busy       = (state_r != IDLE);
  assign finish     = (state_r == DONE);
  assign out        = out_r;
  assign winner_idx = winner_r;
  assign no_winner  = no_winner_r;
  assign timeout    = timeout_r;
  assign iter_count = iter_count_r;

  // Per-channel arithmetic: accumulate step for ACC, inhibited and clamped value for UPDATE.
  always_comb begin
    cur_a_s   = a_r[idx_r];
    cur_ext_s = {{IW{cur_a_s[W-1]}}, cur_a_s};
    last_s    = (idx_r == IDX_LAST);
    acc_sum_s = sum_r + cur_ext_s;
    if (cur_a_s != {W{1'b0}}) begin
      acc_nz_s = nz_r + NZ_ONE;
    end else begin
      acc_nz_s = nz_r;
    end
    // strict compare keeps the lowest index on ties
    if (cur_a_s > max_r) begin
      acc_max_s = cur_a_s;
      acc_arg_s = idx_r;
    end else begin
      acc_max_s = max_r;
      acc_arg_s = arg_r;
    end
    acc_few_s  = (acc_nz_s <= NZ_ONE);
    acc_tmo_s  = !acc_few_s && (iter_r == ITER_LAST);
    // sum is frozen during UPDATE, so every channel sees the previous iteration's values
    diff_s     = sum_r - cur_ext_s;
    eps_ext_s  = {{(PW-W){eps_r[W-1]}}, eps_r};
    diff_ext_s = {{(PW-SW){diff_s[SW-1]}}, diff_s};
    prod_s     = eps_ext_s * diff_ext_s;
    shift_s    = prod_s >>> FRAC;
    sum_new_s  = {shift_s[PW-1], shift_s} + {{(XW-W){cur_a_s[W-1]}}, cur_a_s};
    if (sum_new_s[XW-1]) begin
      upd_a_s = {W{1'b0}};
    end else if (sum_new_s > AMAX_X) begin
      upd_a_s = AMAX_W;
    end else begin
      upd_a_s = sum_new_s[W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; ACC exits on the totals that include the last channel.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (last_s && (acc_few_s || acc_tmo_s)) begin
          state_nxt_s = DONE;
        end else if (last_s) begin
          state_nxt_s = UPDATE;
        end else begin
          state_nxt_s = ACC;
        end
      end
      UPDATE: begin
        if (last_s) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = UPDATE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: capture at start, accumulate, update in place, and latch the result on entering DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) a_r[i] <= {W{1'b0}};
      eps_r        <= {W{1'b0}};
      sum_r        <= {SW{1'b0}};
      nz_r         <= {NW{1'b0}};
      max_r        <= {W{1'b0}};
      arg_r        <= {IW{1'b0}};
      idx_r        <= {IW{1'b0}};
      iter_r       <= {CW{1'b0}};
      out_r        <= {W{1'b0}};
      winner_r     <= {IW{1'b0}};
      no_winner_r  <= 1'b0;
      timeout_r    <= 1'b0;
      iter_count_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            eps_r <= eps;
            for (int i = 0; i < N; i++) begin
              // negative inputs start the run as silent channels
              a_r[i] <= in_flat[i*W + W-1] ? {W{1'b0}} : in_flat[i*W +: W];
            end
            sum_r  <= {SW{1'b0}};
            nz_r   <= {NW{1'b0}};
            max_r  <= {W{1'b0}};
            arg_r  <= {IW{1'b0}};
            idx_r  <= {IW{1'b0}};
            iter_r <= {CW{1'b0}};
          end
        end
        ACC: begin
          sum_r <= acc_sum_s;
          nz_r  <= acc_nz_s;
          max_r <= acc_max_s;
          arg_r <= acc_arg_s;
          if (last_s) begin
            idx_r <= {IW{1'b0}};
            if (acc_few_s || acc_tmo_s) begin
              no_winner_r  <= (acc_nz_s == {NW{1'b0}});
              out_r        <= (acc_nz_s == {NW{1'b0}}) ? {W{1'b0}} : acc_max_s;
              winner_r     <= (acc_nz_s == {NW{1'b0}}) ? {IW{1'b0}} : acc_arg_s;
              timeout_r    <= acc_tmo_s;
              iter_count_r <= iter_r;
            end
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        UPDATE: begin
          a_r[idx_r] <= upd_a_s;
          if (last_s) begin
            idx_r  <= {IW{1'b0}};
            iter_r <= iter_r + ITER_ONE;
            sum_r  <= {SW{1'b0}};
            nz_r   <= {NW{1'b0}};
            max_r  <= {W{1'b0}};
            arg_r  <= {IW{1'b0}};
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        DONE: begin
          idx_r <= {IW{1'b0}};
        end
        default: begin
          idx_r <= {IW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: doc/maxnet_n.md
MAXNET_N -- requirements
Module: maxnet_n

Interface
REQ-001 SHALL have parameter N, default 4, meaning channel count (N >= 2).
REQ-002 SHALL have parameter W, default 16, meaning signed two's-complement activation width.
REQ-003 SHALL have parameter FRAC, default 8, meaning fractional bits of the fixed-point format.
REQ-004 SHALL have parameter MAX_ITER, default 255, meaning iteration limit; IW = clog2(N), CW = clog2(MAX_ITER+1).
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-007 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-008 SHALL have port eps  input  W  signed inhibition weight, captured at start.
REQ-009 SHALL have port in_flat  input  N*W  channel i at bits [i*W +: W], captured at start.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port finish  output  1  one-cycle completion pulse.
REQ-012 SHALL have port out  output  W  winner activation.
REQ-013 SHALL have port winner_idx  output  IW  winner channel.
REQ-014 SHALL have port no_winner  output  1  all activations reached zero.
REQ-015 SHALL have port timeout  output  1  stopped by MAX_ITER.
REQ-016 SHALL have port iter_count  output  CW  completed update iterations.

Function
REQ-017 SHALL implement states IDLE, ACC, UPDATE, DONE.
REQ-018 IDLE, start=1 at edge e0: capture eps; a_i = max(0, in_i) (negative inputs clamped to 0); clear iter, sum, nz_count, max; idx=0; go ACC.
REQ-019 start SHALL be ignored in ACC, UPDATE, DONE.
REQ-020 ACC: one channel per cycle, idx 0..N-1; sum += a_idx (width W+IW, no overflow); nz_count += (a_idx != 0); max/argmax updated on strict greater-than, so the lowest index wins ties.
REQ-021 Exit from ACC at idx=N-1, decided on the totals including a_{N-1}: nz_count <= 1 -> DONE; else iter == MAX_ITER -> DONE with timeout; else -> UPDATE with idx=0.
REQ-022 UPDATE: one channel per cycle; a_i' = clamp(a_i + ((eps * (sum - a_i)) >>> FRAC), 0, 2^(W-1)-1).
REQ-023 The UPDATE product SHALL be full width 2W+IW; the shift is arithmetic (floor); a_i is written in place; sum stays frozen, giving synchronous (Jacobi) update semantics.
REQ-024 After UPDATE idx=N-1: iter += 1; clear sum, nz_count, max; go ACC.
REQ-025 DONE SHALL last exactly one cycle with finish=1, then go IDLE.
REQ-026 On entering DONE, register and hold until the next accepted start: out = max, winner_idx = argmax, iter_count = iter, timeout flag, and no_winner = (nz_count == 0).
REQ-027 When no_winner=1, out=0 and winner_idx=0.
REQ-028 Latency: finish SHALL be high in the cycle following edge e0+N*(2*iter+1); iteration cost is 2N cycles.
REQ-029 eps >= 0 is legal; the run then terminates via the MAX_ITER timeout or all-zero.

Reset
REQ-030 rst=0 SHALL immediately force IDLE and clear busy, finish, out, winner_idx, no_winner, timeout, iter_count, all a_i, sum, and counters to 0, from any state including mid-run.
REQ-031 After rst returns to 1, the first start SHALL behave as a fresh run.

Verification
REQ-032 Single survivor: N=4, W=16, FRAC=8, eps=0xFFCD (-51/256), in=(0,0x0500,0,0) -> finish pulse after edge e0+4, out=0x0500, winner_idx=1, iter_count=0, no_winner=0, timeout=0.
REQ-033 Competition: eps=0xFFCD, in=(512,256,0,0) -> per-iteration values (461,154), (430,62), (417,0) -> out=417, winner_idx=0, iter_count=3, finish after edge e0+28.
REQ-034 Symmetric tie with clamp: eps=0xFFCD, in=(-32435,32435,0,32435) -> a0 clamped to 0; channels 1 and 3 decay identically to 0 -> no_winner=1, out=0, winner_idx=0, timeout=0.
REQ-035 Timeout: eps=0, in=(100,100,0,0) -> iter_count=255, timeout=1, out=100, winner_idx=0.
REQ-036 Reset mid-run: drop rst during UPDATE of REQ-033 -> same cycle busy=0 and all outputs 0; restart -> REQ-033 results reproduced.
REQ-037 Start while busy: pulse start with different inputs during ACC -> ignored; results match the original run.
